// File: rtl/fetch_aligner.sv
`default_nettype none
// ============================================================================
// Module   : fetch_aligner
// Brief    : Word fetch sequencer and instruction aligner between the icache
//            and pre_if. Define FETCH_ALIGN_RVC_EN for 16-bit alignment.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_aligner #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid_i,
    input  logic [31:0] redirect_pc_i,
    output logic        req_valid_o,
    output logic [31:0] req_addr_o,
    input  logic        req_ready_i,
    input  logic        rdata_valid_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] inst_o,
    output logic [31:0] inst_pc_o,
    output logic        inst_valid_o,
    input  logic        inst_ready_i
);

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_WAIT  = 2'd1,
        S_DRAIN = 2'd2,
        S_DROP  = 2'd3
    } state_t;

`ifdef FETCH_ALIGN_RVC_EN
    localparam logic [31:0] C_PC_MASK = 32'hFFFF_FFFE;
`else
    localparam logic [31:0] C_PC_MASK = 32'hFFFF_FFFC;
`endif

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_inst;
    logic [31:0] r_inst_pc;
    logic        r_inst_valid;

    logic        w_out_free;
    logic        w_req_fire;
    logic        w_outstanding;

    // Fetching only when the output slot drains guarantees a response never
    // lands while an instruction is still held.
    assign w_out_free    = !r_inst_valid || inst_ready_i;
    assign req_valid_o   = (r_state == S_REQ) && w_out_free;
    assign w_req_fire    = req_valid_o && req_ready_i;
    assign w_outstanding = (((r_state == S_WAIT) || (r_state == S_DROP)) && !rdata_valid_i)
                           || w_req_fire;

`ifdef FETCH_ALIGN_RVC_EN
    logic [15:0] r_buf;
    logic        r_buf_valid;

    // A held halfword means pc sits at its upper half; fetch the word after it.
    assign req_addr_o = r_buf_valid ? {r_pc[31:2] + 30'd1, 2'b00} : {r_pc[31:2], 2'b00};
`else
    assign req_addr_o = {r_pc[31:2], 2'b00};
`endif

    assign inst_o       = r_inst;
    assign inst_pc_o    = r_inst_pc;
    assign inst_valid_o = r_inst_valid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_REQ;
            r_pc         <= RESET_PC & C_PC_MASK;
            r_inst       <= 32'd0;
            r_inst_pc    <= 32'd0;
            r_inst_valid <= 1'b0;
`ifdef FETCH_ALIGN_RVC_EN
            r_buf        <= 16'd0;
            r_buf_valid  <= 1'b0;
`endif
        end else begin
            if (r_inst_valid && inst_ready_i) begin
                r_inst_valid <= 1'b0;
            end
            if (redirect_valid_i) begin
                r_inst_valid <= 1'b0;
                r_pc         <= redirect_pc_i & C_PC_MASK;
                r_state      <= w_outstanding ? S_DROP : S_REQ;
`ifdef FETCH_ALIGN_RVC_EN
                r_buf_valid  <= 1'b0;
`endif
            end else begin
                case (r_state)
                    S_REQ: begin
                        if (w_req_fire) begin
                            r_state <= S_WAIT;
                        end
                    end
                    S_WAIT: begin
                        if (rdata_valid_i) begin
`ifdef FETCH_ALIGN_RVC_EN
                            if (r_buf_valid) begin
                                r_inst       <= {rdata_i[15:0], r_buf};
                                r_inst_pc    <= r_pc;
                                r_inst_valid <= 1'b1;
                                r_pc         <= r_pc + 32'd4;
                                r_buf        <= rdata_i[31:16];
                                r_state      <= S_DRAIN;
                            end else if (r_pc[1]) begin
                                r_buf        <= rdata_i[31:16];
                                r_buf_valid  <= 1'b1;
                                r_state      <= S_DRAIN;
                            end else if (rdata_i[1:0] == 2'b11) begin
                                r_inst       <= rdata_i;
                                r_inst_pc    <= r_pc;
                                r_inst_valid <= 1'b1;
                                r_pc         <= r_pc + 32'd4;
                                r_state      <= S_REQ;
                            end else begin
                                r_inst       <= {16'h0000, rdata_i[15:0]};
                                r_inst_pc    <= r_pc;
                                r_inst_valid <= 1'b1;
                                r_pc         <= r_pc + 32'd2;
                                r_buf        <= rdata_i[31:16];
                                r_buf_valid  <= 1'b1;
                                r_state      <= S_DRAIN;
                            end
`else
                            r_inst       <= rdata_i;
                            r_inst_pc    <= r_pc;
                            r_inst_valid <= 1'b1;
                            r_pc         <= r_pc + 32'd4;
                            r_state      <= S_REQ;
`endif
                        end
                    end
`ifdef FETCH_ALIGN_RVC_EN
                    S_DRAIN: begin
                        if (r_buf[1:0] == 2'b11) begin
                            r_state <= S_REQ;
                        end else if (w_out_free) begin
                            r_inst       <= {16'h0000, r_buf};
                            r_inst_pc    <= r_pc;
                            r_inst_valid <= 1'b1;
                            r_pc         <= r_pc + 32'd2;
                            r_buf_valid  <= 1'b0;
                            r_state      <= S_REQ;
                        end
                    end
`endif
                    S_DROP: begin
                        if (rdata_valid_i) begin
                            r_state <= S_REQ;
                        end
                    end
                    default: r_state <= S_REQ;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_aligner.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_aligner
// Brief    : Self-checking bench for fetch_aligner against an instruction
//            stream model walking a sparse memory image.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_aligner;

`ifdef FETCH_ALIGN_RVC_EN
    localparam bit          C_RVC     = 1'b1;
    localparam logic [31:0] C_PC_MASK = 32'hFFFF_FFFE;
`else
    localparam bit          C_RVC     = 1'b0;
    localparam logic [31:0] C_PC_MASK = 32'hFFFF_FFFC;
`endif
    localparam logic [31:0] C_RESET_PC = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid_i;
    logic [31:0] redirect_pc_i;
    logic        req_valid_o;
    logic [31:0] req_addr_o;
    logic        req_ready_i;
    logic        rdata_valid_i;
    logic [31:0] rdata_i;
    logic [31:0] inst_o;
    logic [31:0] inst_pc_o;
    logic        inst_valid_o;
    logic        inst_ready_i;

    always #5 clk = ~clk;

    fetch_aligner #(.RESET_PC(C_RESET_PC)) dut (
        .clk             (clk),
        .rst             (rst),
        .redirect_valid_i(redirect_valid_i),
        .redirect_pc_i   (redirect_pc_i),
        .req_valid_o     (req_valid_o),
        .req_addr_o      (req_addr_o),
        .req_ready_i     (req_ready_i),
        .rdata_valid_i   (rdata_valid_i),
        .rdata_i         (rdata_i),
        .inst_o          (inst_o),
        .inst_pc_o       (inst_pc_o),
        .inst_valid_o    (inst_valid_o),
        .inst_ready_i    (inst_ready_i)
    );

    int          n_cmp = 0;
    int          n_fail = 0;
    logic [31:0] mem [logic [29:0]];
    int unsigned ready_pct, inst_ready_pct, lat_min, lat_max;
    bit          pend;
    int unsigned pend_cnt;
    logic [31:0] pend_addr;
    logic [31:0] exp_pc;
    int          n_req, n_inst, last_inst_nreq;
    logic [31:0] req_log[$];
    logic [31:0] acc_inst[$];
    logic [31:0] acc_pc[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (!mem.exists(a[31:2])) mem[a[31:2]] = $urandom;
        return mem[a[31:2]];
    endfunction

    function automatic logic [15:0] half_at(input logic [31:0] a);
        logic [31:0] w;
        w = mem_word(a);
        return a[1] ? w[31:16] : w[15:0];
    endfunction

    task automatic preload(input logic [31:0] a, input logic [31:0] w);
        mem[a[31:2]] = w;
    endtask

    // Next instruction of the program as seen from exp_pc.
    task automatic model_next(output logic [31:0] inst, output logic [31:0] pc);
        logic [15:0] lo;
        pc = exp_pc;
        if (C_RVC) begin
            lo = half_at(exp_pc);
            if (lo[1:0] != 2'b11) begin
                inst   = {16'h0000, lo};
                exp_pc = exp_pc + 32'd2;
            end else begin
                inst   = {half_at(exp_pc + 32'd2), lo};
                exp_pc = exp_pc + 32'd4;
            end
        end else begin
            inst   = mem_word(exp_pc);
            exp_pc = exp_pc + 32'd4;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, expv);
        end
    endtask

    // One clock cycle, entered and left just after the falling edge.
    task automatic cycle();
        logic [31:0] e_inst, e_pc;
        req_ready_i   = ($urandom_range(0, 99) < ready_pct);
        inst_ready_i  = ($urandom_range(0, 99) < inst_ready_pct);
        rdata_valid_i = 1'b0;
        rdata_i       = $urandom;
        if (pend) begin
            if (pend_cnt == 0) begin
                rdata_valid_i = 1'b1;
                rdata_i       = mem_word(pend_addr);
                pend          = 1'b0;
            end else begin
                pend_cnt--;
            end
        end
        #1;
        if (inst_valid_o && inst_ready_i) begin
            model_next(e_inst, e_pc);
            chk("inst", inst_o, e_inst);
            chk("inst_pc", inst_pc_o, e_pc);
            acc_inst.push_back(inst_o);
            acc_pc.push_back(inst_pc_o);
            n_inst++;
            last_inst_nreq = n_req;
        end
        if (redirect_valid_i) exp_pc = redirect_pc_i & C_PC_MASK;
        if (req_valid_o && req_ready_i) begin
            chk("req_align", {30'd0, req_addr_o[1:0]}, 32'd0);
            chk("one_outstanding", {31'd0, pend}, 32'd0);
            pend      = 1'b1;
            pend_cnt  = $urandom_range(lat_min, lat_max);
            pend_addr = req_addr_o;
            req_log.push_back(req_addr_o);
            n_req++;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic redirect(input logic [31:0] pc);
        redirect_valid_i = 1'b1;
        redirect_pc_i    = pc;
        cycle();
        redirect_valid_i = 1'b0;
    endtask

    task automatic clear_logs();
        req_log.delete();
        acc_inst.delete();
        acc_pc.delete();
        n_req  = 0;
        n_inst = 0;
    endtask

    task automatic do_reset();
        rst              = 1'b0;
        redirect_valid_i = 1'b0;
        rdata_valid_i    = 1'b0;
        pend             = 1'b0;
        mem.delete();
        clear_logs();
        exp_pc = C_RESET_PC & C_PC_MASK;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic run_insts(input int n, input string tag);
        int budget;
        budget = 400;
        while (n_inst < n && budget > 0) begin
            cycle();
            budget--;
        end
        chk({tag, "_inst_budget"}, {31'd0, (n_inst >= n)}, 32'd1);
    endtask

    task automatic run_reqs(input int n, input string tag);
        int budget;
        budget = 400;
        while (n_req < n && budget > 0) begin
            cycle();
            budget--;
        end
        chk({tag, "_req_budget"}, {31'd0, (n_req >= n)}, 32'd1);
    endtask

    initial begin
        rst = 1'b0; redirect_valid_i = 1'b0; redirect_pc_i = 32'd0;
        req_ready_i = 1'b0; rdata_valid_i = 1'b0; rdata_i = 32'd0; inst_ready_i = 1'b1;
        ready_pct = 100; inst_ready_pct = 100; lat_min = 0; lat_max = 2;
        pend = 1'b0; exp_pc = C_RESET_PC & C_PC_MASK;
        clear_logs();
        last_inst_nreq = 0;

        // Reset state and first two 32-bit instructions
        repeat (2) @(negedge clk);
        chk("rst_inst_valid", {31'd0, inst_valid_o}, 32'd0);
        chk("rst_inst", inst_o, 32'd0);
        chk("rst_inst_pc", inst_pc_o, 32'd0);
        chk("rst_req_addr", req_addr_o, 32'h8000_0000);
        preload(32'h8000_0000, 32'h0000_0013);
        preload(32'h8000_0004, 32'h0010_0093);
        rst = 1'b1;
        #1;
        chk("rst_req_valid", {31'd0, req_valid_o}, 32'd1);
        @(negedge clk);
        run_insts(2, "basic");
        chk("basic_inst0", acc_inst[0], 32'h0000_0013);
        chk("basic_pc0", acc_pc[0], 32'h8000_0000);
        chk("basic_inst1", acc_inst[1], 32'h0010_0093);
        chk("basic_pc1", acc_pc[1], 32'h8000_0004);
        chk("basic_req1", req_log[1], 32'h8000_0004);

        // Compressed pair from one word
        do_reset();
        preload(32'h8000_0000, 32'h4501_4581);
        run_insts(2, "pair");
        chk("pair_inst0", acc_inst[0], C_RVC ? 32'h0000_4581 : 32'h4501_4581);
        chk("pair_pc1", acc_pc[1], C_RVC ? 32'h8000_0002 : 32'h8000_0004);
        chk("pair_fetches", last_inst_nreq, C_RVC ? 32'd1 : 32'd2);

        // 32-bit instruction straddling a word boundary
        do_reset();
        preload(32'h8000_0000, 32'h0013_4581);
        preload(32'h8000_0004, 32'h0413_0013);
        preload(32'h8000_0008, 32'h0000_0001);
        run_insts(3, "straddle");
        chk("straddle_inst1", acc_inst[1], C_RVC ? 32'h0013_0013 : 32'h0413_0013);
        chk("straddle_pc1", acc_pc[1], C_RVC ? 32'h8000_0002 : 32'h8000_0004);
        chk("straddle_inst2", acc_inst[2], C_RVC ? 32'h0001_0413 : 32'h0000_0001);
        chk("straddle_req1", req_log[1], 32'h8000_0004);

        // Redirect while a response is outstanding
        do_reset();
        preload(32'h8000_0000, 32'h0000_0013);
        preload(32'h8000_0104, 32'h4501_0013);
        lat_min = 4; lat_max = 4;
        run_reqs(1, "drop");
        redirect(32'h8000_0106);
        clear_logs();
        lat_min = 0; lat_max = 2;
        run_insts(1, "drop");
        chk("drop_req0", req_log[0], 32'h8000_0104);
        chk("drop_pc0", acc_pc[0], C_RVC ? 32'h8000_0106 : 32'h8000_0104);
        chk("drop_inst0", acc_inst[0], C_RVC ? 32'h0000_4501 : 32'h4501_0013);

        // Backpressure: held output stays put, nothing else fetched
        do_reset();
        preload(32'h8000_0000, 32'h4501_4581);
        inst_ready_pct = 0;
        for (int i = 0; i < 50 && !inst_valid_o; i++) cycle();
        chk("bp_valid", {31'd0, inst_valid_o}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("bp_inst_hold", inst_o, C_RVC ? 32'h0000_4581 : 32'h4501_4581);
            chk("bp_pc_hold", inst_pc_o, 32'h8000_0000);
            chk("bp_valid_hold", {31'd0, inst_valid_o}, 32'd1);
            chk("bp_no_fetch", n_req, 32'd1);
        end
        inst_ready_pct = 100;
        run_insts(3, "bp");

        // Address wrap past the top of memory
        do_reset();
        preload(32'hFFFF_FFFC, 32'h0000_0013);
        redirect(32'hFFFF_FFFC);
        clear_logs();
        run_reqs(2, "wrap");
        chk("wrap_req0", req_log[0], 32'hFFFF_FFFC);
        chk("wrap_req1", req_log[1], 32'h0000_0000);
        run_insts(2, "wrap");
        chk("wrap_pc0", acc_pc[0], 32'hFFFF_FFFC);

        // Randomized traffic with redirects and stalls on both sides
        do_reset();
        ready_pct = 70; inst_ready_pct = 70; lat_min = 0; lat_max = 3;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) < 3)
                redirect(32'h8000_0000 + ($urandom_range(0, 255) << 1));
            else
                cycle();
        end
        chk("rand_progress", {31'd0, (n_inst > 100)}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
